// File: rtl/amber48_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// amber48_uart_tx : FIFO-buffered 8N1 serial transmitter for the dmem UART port
// Revision 1.0
// ============================================================================
module amber48_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          tx_valid_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_enable_i,
  input  logic                          clr_overflow_i,
  output logic                          uart_txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          fifo_full_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   baud_cnt, baud_next;
  logic [2:0]      bit_idx, bit_next;
  logic [7:0]      shift, shift_next;
  logic            txd, txd_next;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level;
  logic            overflow;

  logic            bit_end, can_pop, pop, push, full, overflow_set;

  assign full         = (level == LEVEL_FULL);
  assign bit_end      = (baud_cnt == BAUD_LAST);
  assign can_pop      = (level != '0) && tx_enable_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push         = tx_valid_i && (!full || pop);
  assign overflow_set = tx_valid_i && full && !pop;

  always_comb begin
    state_next = state;
    baud_next  = bit_end ? '0 : baud_cnt + CW'(1);
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (can_pop) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift[7:1]};
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (can_pop) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from the next state so the pin itself is a flop.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      txd      <= txd_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (overflow_set)        overflow <= 1'b1;
      else if (clr_overflow_i) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= tx_data_i;
  end

  assign uart_txd_o   = txd;
  assign busy_o       = (state != IDLE);
  assign fifo_level_o = level;
  assign fifo_full_o  = full;
  assign overflow_o   = overflow;

endmodule
`default_nettype wire

// File: doc/amber48_uart_tx.md
Name: amber48_uart_tx

Overview:
- Serial transmitter directly downstream of the amber48 data-memory UART port.
- Accepts the single-cycle uart_tx_valid/uart_tx_data byte strobes produced by dmem MMIO stores.
- Buffers the bytes in a small FIFO and shifts them out as 8N1 frames on a single TXD pin.
- The dmem side has no backpressure, so the block reports overflow instead of stalling the core.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal values 2 and up.
FIFO_DEPTH, 16, byte FIFO entries; must be a power of two and at least 2.

Ports:
clk_i  input  1  system clock; all state updates on the rising edge.
rst_ni  input  1  asynchronous, active-low reset.
tx_valid_i  input  1  single-cycle byte strobe from dmem uart_tx_valid_o.
tx_data_i  input  8  byte to send; sampled when tx_valid_i=1.
tx_enable_i  input  1  when 0, no new frame starts; a frame already in progress completes.
clr_overflow_i  input  1  synchronous clear of overflow_o.
uart_txd_o  output  1  serial line; idle high; registered output.
busy_o  output  1  1 while a frame is in progress (FSM not IDLE).
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte being shifted.
fifo_full_o  output  1  fifo_level_o == FIFO_DEPTH.
overflow_o  output  1  sticky flag: a byte was dropped.

Behaviour:
- Reset values (asynchronous, rst_ni=0): uart_txd_o=1, busy_o=0, fifo_level_o=0, fifo_full_o=0, overflow_o=0, FSM=IDLE, baud and bit counters=0, FIFO pointers=0.
- Reset mid-frame aborts the frame; the line returns high immediately and FIFO contents are discarded.
- FIFO push: on any edge with tx_valid_i=1 and the FIFO not full, tx_data_i is written at the write pointer.
- Pointers wrap modulo FIFO_DEPTH.
- FIFO pop: occurs only on the FSM IDLE->START or STOP->START transition.
- Simultaneous push and pop:
  - Both are performed and the level is unchanged.
  - When the FIFO is full, the pop frees a slot in the same cycle, so the push is accepted and overflow is not set.
- Overflow: when tx_valid_i=1, the FIFO is full and there is no pop that cycle:
  - The byte is dropped and FIFO contents are unchanged.
  - overflow_o is set on that edge.
  - Set has priority over a clr_overflow_i in the same cycle.
  - The flag holds until clr_overflow_i=1 or reset.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - uart_txd_o=1.
  - If fifo_level_o>0 and tx_enable_i=1, pop the head into the shift register, load baud_cnt=0 and go to START.
  - uart_txd_o=0 from that edge.
- START: drive 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA:
  - Drive shift[0]; each bit lasts CLKS_PER_BIT cycles and the frame is sent LSB first.
  - At the end of each bit, shift right and increment bit_idx.
  - After bit 7 completes, go to STOP.
- STOP: drive 1 for CLKS_PER_BIT cycles. At the end:
  - If fifo_level_o>0 and tx_enable_i=1, pop and go directly to START with no idle gap.
  - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every bit boundary and every state change.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: byte pushed at edge N into an empty FIFO with an idle FSM:
  - FIFO level becomes 1 after edge N.
  - Pop occurs at edge N+1 and uart_txd_o falls after edge N+1.
  - fifo_level_o returns to 0 after edge N+1.
- tx_enable_i deassertion:
  - Checked only at pop points, never mid-frame.
  - Bytes remain queued and pushes continue.
- busy_o=1 in START, DATA and STOP; 0 in IDLE.

Test Plan:
- CLKS_PER_BIT=4, FIFO_DEPTH=4: reset, single push 0x55 -> uart_txd_o low after edge N+1, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high, busy_o=0 after 40 frame cycles, fifo_level_o 1->0.
- Push 0x41, 0x42, 0x43 on consecutive cycles -> three frames back-to-back with no idle cycles between stop bit and next start bit; decoded bytes 0x41, 0x42, 0x43 in order; level peaks at 2.
- With tx_enable_i=0, push 6 bytes 0x10..0x15 -> first 4 queued, fifo_full_o=1, overflow_o=1 after the 5th push, level stays 4; pulse clr_overflow_i -> overflow_o=0; set tx_enable_i=1 -> 0x10..0x13 transmitted.
- With the FIFO full and the FSM at STOP end performing a pop, push 0x99 on the same edge -> accepted, overflow_o stays 0, level stays 4, 0x99 transmitted last.
- Assert rst_ni=0 mid-DATA of byte 0x00 (line low) -> uart_txd_o=1 immediately without waiting for a clock, level=0, busy_o=0; after release no frame is sent.
- Deassert tx_enable_i mid-frame of 0xA5 with 0x5A queued -> 0xA5 completes with full stop bit, line stays idle high, level stays 1 until re-enabled.
